// File: rtl/ew_sequence_driver.sv
// ew_sequence_driver: buffers a short sequence of (e,w) symbols and plays it
// onto registered e/w outputs. Each symbol is held for HOLD clocks. After the
// last symbol the block drives idle (00) for one cycle, captures the
// detector's response into `result`, and pulses `done`.
module ew_sequence_driver #(
  parameter int DEPTH = 8,   // symbol buffer entries, power of 2, 2..16
  parameter int HOLD  = 1,   // clocks per symbol, 1..15
  parameter int CW    = 5    // width of count, must be able to hold DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [1:0]    wr_sym,
  input  logic          start,
  input  logic          det_out,
  output logic          e,
  output logic          w,
  output logic          busy,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          result
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RESP,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [1:0]      r_buf [DEPTH];
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_rd_idx;
  logic [AW-1:0]   w_rd_next;
  logic [3:0]      r_hold;
  logic            r_e;
  logic            r_w;
  logic            r_result;

  logic            w_full;
  logic            w_wr_ok;
  logic            w_start_ok;
  logic            w_hold_done;
  logic            w_last;

  // A write is accepted only in IDLE and only while there is room. A start
  // needs at least one symbol loaded before this edge; a write in the same
  // cycle is still appended and becomes part of the run.
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_wr_ok     = (r_state == S_IDLE) && wr_en && !w_full;
  assign w_start_ok  = (r_state == S_IDLE) && start && (r_count != '0);
  assign w_hold_done = (r_hold == 4'(HOLD));
  assign w_last      = (({{(CW-AW){1'b0}}, r_rd_idx} + 1'b1) == r_count);
  assign w_rd_next   = r_rd_idx + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: assign a default first so no path leaves the output unassigned,
    // which would otherwise infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok)          w_next_state = S_SEND;
      S_SEND: if (w_hold_done && w_last) w_next_state = S_RESP;
      S_RESP:                          w_next_state = S_DONE;
      S_DONE:                          w_next_state = S_IDLE;
      default:                         w_next_state = S_IDLE;
    endcase
  end

  // Symbol storage; written only in IDLE at index count.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; its contents are only ever read at
    // indices below count, and count is cleared by reset.
    if (!rst && w_wr_ok) r_buf[r_count[AW-1:0]] <= wr_sym;
  end

  // Datapath: fill level, read pointer, hold counter, e/w drive, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_rd_idx <= '0;
      r_hold   <= '0;
      r_e      <= 1'b0;
      r_w      <= 1'b0;
      r_result <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_ok) r_count <= r_count + 1'b1;
          if (w_start_ok) begin
            r_rd_idx   <= '0;
            r_hold     <= 4'd1;
            {r_e, r_w} <= r_buf[0];
          end
        end
        S_SEND: begin
          if (w_hold_done) begin
            if (w_last) begin
              {r_e, r_w} <= 2'b00;
            end else begin
              r_rd_idx   <= w_rd_next;
              r_hold     <= 4'd1;
              {r_e, r_w} <= r_buf[w_rd_next];
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_RESP: begin
          r_result <= det_out;
          r_count  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign e      = r_e;
  assign w      = r_w;
  assign busy   = (r_state == S_SEND) || (r_state == S_RESP);
  assign done   = (r_state == S_DONE);
  assign full   = w_full;
  assign count  = r_count;
  assign result = r_result;

endmodule
